// File: rtl/md_sched_pkg.sv
// md_sched_pkg: md-unit operation codes, default latencies and the instruction encodings the control unit decodes into E_md_op.
package md_sched_pkg;
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;
  typedef enum logic {S_IDLE, S_BUSY} md_state_t;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
endpackage

// File: rtl/md_sched_if.sv
// md_sched_if: E/D-stage request side and HI/LO/stall result side of the multiply/divide unit.
interface md_sched_if #(parameter int WIDTH = 32);
  logic [3:0] E_md_op;
  logic [WIDTH-1:0] E_a, E_b;
  logic D_md_use, busy, stall;
  logic [WIDTH-1:0] hi, lo, md_rdata;
  modport master(output E_md_op, E_a, E_b, D_md_use, input busy, stall, hi, lo, md_rdata);
  modport slave(input E_md_op, E_a, E_b, D_md_use, output busy, stall, hi, lo, md_rdata);
endinterface

// File: rtl/md_sched_arith.sv
// md_arith: combinational signed/unsigned multiply and divide producing HI/LO halves.
module md_arith
  import md_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);
  logic signed [2*WIDTH-1:0] sa, sb;
  logic uns;
  // Double-width signed operands keep MIN/-1 from overflowing and make unsigned ops a zero-extended special case
  always_comb begin
    uns = op == MD_MULTU || op == MD_DIVU;
    sa = uns ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
    sb = uns ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
    div_zero = (op == MD_DIV || op == MD_DIVU) && b == '0;
    {res_hi, res_lo} = sa * sb;
    if (op == MD_DIV || op == MD_DIVU) begin
      res_lo = div_zero ? '0 : WIDTH'(sa / sb);
      res_hi = div_zero ? '0 : WIDTH'(sa % sb);
    end
  end
endmodule

// File: rtl/md_sched.sv
// md_sched: HI/LO owner that sequences multi-cycle mult/div from E and stalls md-class ops in D while occupied.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  md_sched_if.slave md
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  md_state_t state;
  md_op_t op;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi_r, lo_r, res_hi, res_lo, a_hi, a_lo;
  logic res_zero, a_zero, busy_r, start;
  assign op = md_op_t'(md.E_md_op);
  assign start = state == S_IDLE && (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU);
  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op(op), .a(md.E_a), .b(md.E_b), .res_hi(a_hi), .res_lo(a_lo), .div_zero(a_zero)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      hi_r <= '0;
      lo_r <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_zero <= 1'b0;
      busy_r <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        res_hi <= a_hi;
        res_lo <= a_lo;
        res_zero <= a_zero;
        cnt <= (op == MD_MULT || op == MD_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        busy_r <= 1'b1;
        state <= S_BUSY;
      end else if (op == MD_MTHI) hi_r <= md.E_a;
      else if (op == MD_MTLO) lo_r <= md.E_a;
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state <= S_IDLE;
        busy_r <= 1'b0;
        if (!res_zero) begin
          hi_r <= res_hi;
          lo_r <= res_lo;
        end
      end
    end
  assign md.busy = busy_r;
  assign md.stall = !reset && md.D_md_use && (start || busy_r);
  assign md.hi = hi_r;
  assign md.lo = lo_r;
  assign md.md_rdata = op == MD_MFHI ? hi_r : op == MD_MFLO ? lo_r : '0;
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler for the 5-stage MIPS pipeline. It owns the HI/LO registers and sequences multi-cycle MULT/MULTU/DIV/DIVU issued from the E stage.
- It handles MTHI/MTLO/MFHI/MFLO.
- It raises a stall request so that any D-stage multiply/divide-class instruction waits while the unit is occupied.
- It sits beside the ALU in E; its stall output is ORed into the D-stage hazard stall.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- E_md_op  in  4  E-stage operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; other codes are treated as NONE.
- E_a  in  WIDTH  rs operand, already forwarded.
- E_b  in  WIDTH  rt operand, already forwarded.
- D_md_use  in  1  D-stage instruction is any md-class op (codes 1-8).
- busy  out  1  unit is computing.
- stall  out  1  D-stage stall request.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- md_rdata  out  WIDTH  E-stage read result for MFHI/MFLO.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, cnt=0, hi=0, lo=0, busy=0, any pending result discarded.
  - stall=0 while reset is asserted.
- States:
  - IDLE: start = E_md_op in {1..4}.
    - On start, compute the result (via md_arith) into shadow registers res_hi/res_lo.
    - Load cnt with MULT_CYCLES for MULT/MULTU, or DIV_CYCLES for DIV/DIVU.
    - Go to BUSY.
  - BUSY: cnt decrements each cycle.
    - When cnt==1: commit res_hi->hi, res_lo->lo at that edge, go to IDLE.
- Timing:
  - busy=1 for exactly N cycles, starting the cycle after start.
  - The new hi/lo values are visible the first cycle busy=0.
- stall = D_md_use && (start || busy).
  - Combinational; a start cycle also stalls a following md op.
- E_md_op 1..4 arriving while BUSY cannot occur because stall prevents it. If it does occur, it is ignored: no restart, and the counter is unaffected.
- MTHI/MTLO, only legal in IDLE:
  - hi<=E_a or lo<=E_a at the edge.
  - Ignored if BUSY.
- MFHI/MFLO: md_rdata = hi (code 7) or lo (code 8), combinational; md_rdata=0 for other codes.
- Arithmetic:
  - MULT: signed 64-bit product; hi=product[63:32], lo=product[31:0].
  - MULTU: same split, unsigned operands.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with the dividend's sign.
    - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - Divide by zero (E_b==0): the unit still goes BUSY for DIV_CYCLES, but hi/lo are left unchanged at commit.
- Boundaries:
  - With N=1, busy is high for one cycle and commit happens at the following edge.
  - Back-to-back starts are only possible on the cycle after busy falls.

Decomposition:
- Shared constants file (alongside the existing instruction macros):
  - md_op codes 0-8.
  - Default MULT_CYCLES and DIV_CYCLES.
  - Opcode/funct macros for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO (decoded by the control unit into E_md_op).
- One sub-module, md_arith:
  - Purely combinational.
  - Inputs: op, a, b. Outputs: res_hi, res_lo, div_zero.
- md_sched holds the FSM, counter, shadow and HI/LO registers.

Test Plan:
- MULT: a=0xFFFFFFFE (-2), b=3 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV: a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU: a=7, b=2 -> lo=3, hi=1. DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Stall: D_md_use=1 on the start cycle and during busy -> stall=1 for 6 consecutive cycles (MULT); stall=0 the first cycle busy=0. With D_md_use=0 throughout, stall stays 0.
- MTHI a=0x12345678, then MFLO/MFHI -> md_rdata shows lo, then 0x12345678. MTLO while busy -> ignored; lo takes the commit value.
- Divide by zero: hi=0xAAAA0000, lo=0x5555, DIV b=0 -> busy for 10 cycles; hi/lo unchanged afterwards.
- Assert reset at busy cycle 3 of a DIV -> immediately busy=0, hi=lo=0, state IDLE; after release, a new MULT runs normally.
